// File: rtl/data_mem_responder_pkg.sv
// rtl/data_mem_responder_pkg.sv - shared core constants for the data memory responder
package data_mem_responder_pkg;

  localparam logic [31:0] ADDR_CYCLE      = 32'hFFFF_0000;
  localparam logic [31:0] ADDR_TEST       = 32'hFFFF_0004;
  localparam int          DEFAULT_LATENCY = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  function automatic logic [31:0] apply_strb(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/data_mem_responder_byte_ram.sv
// rtl/data_mem_responder_byte_ram.sv - single-port byte-writable RAM with registered read
module byte_ram #(
  parameter int DEPTH_WORDS = 4096,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          i_en,
  input  logic          i_we,
  input  logic [3:0]    i_wstrb,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_rdata;

  // Read register only loads on a read access, so it holds across a stalled response.
  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        for (int i = 0; i < 4; i++) begin
          if (i_wstrb[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
        end
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - fixed-latency data memory responder with RAM, CYCLE and TEST MMIO
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 4096,
  parameter int LATENCY     = DEFAULT_LATENCY
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] test_out
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_t      r_state;
  logic [3:0]  r_lat;
  logic [31:0] r_cycle;
  logic [31:0] r_test;
  logic [31:0] r_cap;
  logic        r_err;
  logic        r_we;
  logic        r_sel_ram;

  logic        w_accept;
  logic        w_is_ram;
  logic        w_is_cycle;
  logic        w_is_test;
  logic        w_err;
  logic        w_ram_en;
  logic        w_rd_ok;
  logic [31:0] w_ram_rdata;

  assign w_accept   = req_valid && (r_state == S_IDLE);
  assign w_is_ram   = (req_addr[31:AW+2] == '0);
  assign w_is_cycle = (req_addr == ADDR_CYCLE);
  assign w_is_test  = (req_addr == ADDR_TEST);
  assign w_err      = (req_addr[1:0] != 2'b00) || !(w_is_ram || w_is_cycle || w_is_test) ||
                      (w_is_cycle && req_we);
  assign w_ram_en   = w_accept && !w_err && w_is_ram;

  byte_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .clk     (clk),
    .i_en    (w_ram_en),
    .i_we    (req_we),
    .i_wstrb (req_wstrb),
    .i_addr  (req_addr[AW+1:2]),
    .i_wdata (req_wdata),
    .o_rdata (w_ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) r_cycle <= '0;
    else     r_cycle <= r_cycle + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_lat     <= '0;
      r_test    <= '0;
      r_cap     <= '0;
      r_err     <= 1'b0;
      r_we      <= 1'b0;
      r_sel_ram <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_err     <= w_err;
            r_we      <= req_we;
            r_sel_ram <= w_is_ram;
            // MMIO read data is snapshotted here; RAM data comes from the RAM read register.
            r_cap     <= w_is_cycle ? r_cycle : r_test;
            r_lat     <= 4'(LATENCY - 1);
            if (!w_err && w_is_test && req_we) r_test <= apply_strb(r_test, req_wdata, req_wstrb);
            r_state   <= (LATENCY == 1) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          r_lat <= r_lat - 4'd1;
          if (r_lat == 4'd1) r_state <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = (r_state == S_IDLE);
  assign resp_valid = (r_state == S_RESP);
  assign w_rd_ok    = resp_valid && !r_err && !r_we;
  assign resp_rdata = w_rd_ok ? (r_sel_ram ? w_ram_rdata : r_cap) : '0;
  assign resp_err   = resp_valid && r_err;
  assign test_out   = r_test;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - table-driven scoreboard bench for data_mem_responder
module tb_data_mem_responder;

  localparam int DEPTH_WORDS = 4096;
  localparam int LATENCY     = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] test_out;

  data_mem_responder #(.DEPTH_WORDS(DEPTH_WORDS), .LATENCY(LATENCY)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_wstrb  (req_wstrb),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .test_out   (test_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic        cyc;
    logic [31:0] rdata;
    logic        err;
    logic        chk_test;
    logic [31:0] test;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Reference cycle counter, reset and advanced like the design's free-running counter.
  logic [31:0] m_cyc = '0;
  always @(posedge clk) begin
    if (rst) m_cyc <= '0;
    else     m_cyc <= m_cyc + 32'd1;
  end

  function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] strb, input logic cyc, input logic [31:0] rdata,
                              input logic err, input logic chk_test, input logic [31:0] test);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.strb = strb; v.cyc = cyc;
    v.rdata = rdata; v.err = err; v.chk_test = chk_test; v.test = test;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic wait_resp(input string name, output int n);
    n = 1;
    while (!resp_valid && n < 40) begin
      check({name, "_quiet"}, {31'd0, resp_err} | resp_rdata, 32'd0);
      @(negedge clk);
      n++;
    end
    check({name, "_latency"}, 32'(n), 32'(LATENCY));
  endtask

  task automatic pop_compare(input string name, output exp_t e);
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s_sb: got response with empty scoreboard want none", name);
      e.rdata = '0; e.err = 1'b0;
    end else begin
      e = sb.pop_front();
      check({name, "_valid"}, {31'd0, resp_valid}, 32'd1);
      check({name, "_rdata"}, resp_rdata, e.rdata);
      check({name, "_err"}, {31'd0, resp_err}, {31'd0, e.err});
    end
  endtask

  task automatic handshake(input string name);
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    check({name, "_ready_after"}, {31'd0, req_ready}, 32'd1);
    check({name, "_valid_after"}, {31'd0, resp_valid}, 32'd0);
  endtask

  task automatic run_vec(input string name, input vec_t v);
    int   n;
    exp_t e;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({name, "_idle"}, {31'd0, req_ready}, 32'd1);
    req_we = v.we; req_addr = v.addr; req_wdata = v.wdata; req_wstrb = v.strb;
    req_valid = 1'b1;
    e.rdata = v.cyc ? m_cyc : v.rdata;
    e.err   = v.err;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    if (v.chk_test) check({name, "_test_out"}, test_out, v.test);
    wait_resp(name, n);
    pop_compare(name, e);
    handshake(name);
  endtask

  initial begin
    int   n;
    logic seen;
    exp_t e;

    vecs.push_back(mk(1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 32'h0,         0, 0, 0));
    vecs.push_back(mk(0, 32'h0000_0010, 32'h0,         4'h0, 0, 32'hDEAD_BEEF, 0, 0, 0));
    vecs.push_back(mk(1, 32'h0000_0010, 32'h0000_00AA, 4'h1, 0, 32'h0,         0, 0, 0));
    vecs.push_back(mk(0, 32'h0000_0010, 32'h0,         4'h0, 0, 32'hDEAD_BEAA, 0, 0, 0));
    vecs.push_back(mk(1, 32'h0000_0014, 32'h1122_3344, 4'hF, 0, 32'h0,         0, 0, 0));
    vecs.push_back(mk(1, 32'h0000_0014, 32'hFFFF_FFFF, 4'h0, 0, 32'h0,         0, 0, 0));
    vecs.push_back(mk(0, 32'h0000_0014, 32'h0,         4'h0, 0, 32'h1122_3344, 0, 0, 0));
    vecs.push_back(mk(0, 32'h0000_0012, 32'h0,         4'h0, 0, 32'h0,         1, 0, 0));
    vecs.push_back(mk(0, 32'h0001_0000, 32'h0,         4'h0, 0, 32'h0,         1, 0, 0));
    vecs.push_back(mk(1, 32'hFFFF_0000, 32'h1234_5678, 4'hF, 0, 32'h0,         1, 0, 0));
    vecs.push_back(mk(0, 32'hFFFF_0000, 32'h0,         4'h0, 1, 32'h0,         0, 0, 0));
    vecs.push_back(mk(0, 32'hFFFF_0000, 32'h0,         4'h0, 1, 32'h0,         0, 0, 0));
    vecs.push_back(mk(1, 32'h0000_0011, 32'h1234_5678, 4'hF, 0, 32'h0,         1, 0, 0));
    vecs.push_back(mk(1, 32'h0000_4000, 32'h1234_5678, 4'hF, 0, 32'h0,         1, 0, 0));
    vecs.push_back(mk(1, 32'h0000_3FFC, 32'hCAFE_F00D, 4'hF, 0, 32'h0,         0, 0, 0));
    vecs.push_back(mk(0, 32'h0000_3FFC, 32'h0,         4'h0, 0, 32'hCAFE_F00D, 0, 0, 0));
    vecs.push_back(mk(0, 32'h0000_0010, 32'h0,         4'h0, 0, 32'hDEAD_BEAA, 0, 0, 0));
    vecs.push_back(mk(1, 32'hFFFF_0004, 32'h0000_0005, 4'hF, 0, 32'h0,         0, 1, 32'h5));
    vecs.push_back(mk(0, 32'hFFFF_0004, 32'h0,         4'h0, 0, 32'h0000_0005, 0, 0, 0));
    vecs.push_back(mk(1, 32'hFFFF_0004, 32'h0000_AB00, 4'h2, 0, 32'h0,         0, 1, 32'hAB05));
    vecs.push_back(mk(0, 32'hFFFF_0004, 32'h0,         4'h0, 0, 32'h0000_AB05, 0, 0, 0));
    vecs.push_back(mk(1, 32'h0000_0020, 32'h0101_0101, 4'hF, 0, 32'h0,         0, 0, 0));
    vecs.push_back(mk(0, 32'hFFFF_0008, 32'h0,         4'h0, 0, 32'h0,         1, 0, 0));

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_req_ready", {31'd0, req_ready}, 32'd1);
    check("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("reset_resp_rdata", resp_rdata, 32'd0);
    check("reset_resp_err", {31'd0, resp_err}, 32'd0);
    check("reset_test_out", test_out, 32'd0);

    for (int i = 0; i < vecs.size(); i++) run_vec($sformatf("v%0d", i), vecs[i]);

    // Stall in RESP while a write to 0x20 is held on the request port; it must never be taken.
    @(negedge clk);
    req_we = 1'b0; req_addr = 32'h0000_0020; req_wstrb = 4'h0; req_valid = 1'b1;
    e.rdata = 32'h0101_0101; e.err = 1'b0;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    req_we = 1'b1; req_wdata = 32'hFFFF_FFFF; req_wstrb = 4'hF;
    wait_resp("stall", n);
    pop_compare("stall", e);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("stall%0d_valid", k), {31'd0, resp_valid}, 32'd1);
      check($sformatf("stall%0d_rdata", k), resp_rdata, e.rdata);
      check($sformatf("stall%0d_req_ready", k), {31'd0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    req_valid  = 1'b0;
    check("stall_ready_after", {31'd0, req_ready}, 32'd1);
    check("stall_valid_after", {31'd0, resp_valid}, 32'd0);
    run_vec("stall_noaccept", mk(0, 32'h0000_0020, 32'h0, 4'h0, 0, 32'h0101_0101, 0, 0, 0));

    // Reset one cycle after accepting a read: the response must vanish.
    @(negedge clk);
    req_we = 1'b0; req_addr = 32'h0000_0010; req_wstrb = 4'h0; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("midrst_test_out", test_out, 32'd0);
    check("midrst_req_ready", {31'd0, req_ready}, 32'd1);
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (resp_valid) seen = 1'b1;
      @(negedge clk);
    end
    check("midrst_no_resp", {31'd0, seen}, 32'd0);
    run_vec("post_rst_ram", mk(0, 32'h0000_0010, 32'h0, 4'h0, 0, 32'hDEAD_BEAA, 0, 0, 0));
    run_vec("post_rst_cyc", mk(0, 32'hFFFF_0000, 32'h0, 4'h0, 1, 32'h0, 0, 0, 0));
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 4096, number of 32-bit RAM words (power of two).
REQ-002 SHALL have parameter LATENCY, default 2, cycles from request acceptance to resp_valid (legal range 1..15).
REQ-003 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_valid  input  1  core presents a request.
REQ-006 SHALL have port req_ready  output  1  responder accepts a request this cycle.
REQ-007 SHALL have port req_we  input  1  1 = write, 0 = read.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  write data.
REQ-010 SHALL have port req_wstrb  input  4  byte enables; bit i covers wdata[8i+7:8i].
REQ-011 SHALL have port resp_valid  output  1  response available.
REQ-012 SHALL have port resp_ready  input  1  core consumes the response.
REQ-013 SHALL have port resp_rdata  output  32  read data; 0 for writes and errors.
REQ-014 SHALL have port resp_err  output  1  request was misaligned, unmapped or illegal.
REQ-015 SHALL have port test_out  output  32  value of the TEST MMIO register.

Function
REQ-016 SHALL decode: RAM at 0x0000_0000..DEPTH_WORDS*4-1; CYCLE (read-only) at 0xFFFF_0000; TEST (read/write) at 0xFFFF_0004; all other addresses unmapped.
REQ-017 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE; req_ready = 1 only in IDLE.
REQ-018 SHALL accept a request on a cycle with req_valid && req_ready, capture all req_* fields, load latency counter with LATENCY-1, and enter WAIT (or RESP directly when LATENCY = 1).
REQ-019 SHALL decrement the counter in WAIT and enter RESP when it reaches 0; resp_valid asserts exactly LATENCY cycles after the acceptance edge.
REQ-020 SHALL hold resp_valid, resp_rdata and resp_err stable in RESP until resp_valid && resp_ready; then return to IDLE, with req_ready = 1 on the following cycle.
REQ-021 SHALL perform RAM/TEST writes on the acceptance edge, per byte under req_wstrb; wstrb = 0 writes nothing but still responds with err = 0.
REQ-022 SHALL return RAM/TEST read data as the contents at the acceptance edge; CYCLE read returns the counter value on the acceptance cycle.
REQ-023 SHALL flag resp_err = 1 and perform no state change for: req_addr[1:0] != 0, unmapped address, or write to CYCLE.
REQ-024 SHALL keep a 32-bit free-running cycle counter, +1 every cycle, wrapping 0xFFFF_FFFF -> 0.
REQ-025 SHALL ignore req_valid outside IDLE (no capture, no side effect).
REQ-026 SHALL drive resp_valid = 0, resp_rdata = 0 and resp_err = 0 whenever not in RESP.

Reset
REQ-027 SHALL on rst: state IDLE, req_ready = 1 on the next cycle, resp_valid = 0, resp_rdata = 0, resp_err = 0, latency counter 0, cycle counter 0, TEST = 0 (test_out = 0).
REQ-028 SHALL on rst mid-transaction drop the in-flight response without emitting it; a write already performed at acceptance stays performed.
REQ-029 SHALL not clear RAM contents on reset.

Structure
REQ-030 SHALL take the address constants (ADDR_CYCLE, ADDR_TEST), the FSM state encoding and the default LATENCY from the shared core package.
REQ-031 SHALL instantiate one sub-module, byte_ram (single-port, DEPTH_WORDS x 32, 4 byte write enables, synchronous write, registered read), for the RAM array.

Verification
REQ-032 Scenario: write 0xDEADBEEF to 0x10 with wstrb = 0xF, then read 0x10 -> second response rdata = 0xDEADBEEF, err = 0, resp_valid exactly LATENCY cycles after each accept.
REQ-033 Scenario: over 0x10 = 0xDEADBEEF, write 0x000000AA with wstrb = 0x1, then read -> rdata = 0xDEADBEAA.
REQ-034 Scenario: read 0x12 (misaligned), read 0x0001_0000 with DEPTH_WORDS = 4096 (unmapped), write 0xFFFF_0000 -> each err = 1, rdata = 0; CYCLE still incrementing and RAM unchanged.
REQ-035 Scenario: write 0x5 to 0xFFFF_0004 -> test_out = 0x5 the cycle after accept; assert rst -> test_out = 0.
REQ-036 Scenario: hold resp_ready = 0 for 5 cycles in RESP with req_valid = 1 -> response stable, req_ready = 0, no second accept; resp_ready = 1 -> req_ready = 1 the next cycle.
REQ-037 Scenario: rst asserted one cycle after accepting a read -> no resp_valid ever appears for it; next request served normally.
